// File: rtl/johnson_decoder.sv
// Johnson-code receiver: validates and decodes sampled Johnson words to a binary step index,
// and tracks lock to a stream that advances one legal step at a time.
module johnson_decoder #(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned LOCK_COUNT = 2,
    localparam int unsigned CW        = $clog2(2 * WIDTH)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Valid_in,
    input  logic [WIDTH-1:0] Johnson_in,
    output logic [CW-1:0]    Count_out,
    output logic             Count_valid,
    output logic             Code_error,
    output logic             Seq_error,
    output logic             Locked,
    output logic [7:0]       Error_count
);

    localparam logic [CW:0] ModVal  = (CW + 1)'(2 * WIDTH);
    localparam logic [3:0]  LockRun = 4'(LOCK_COUNT);

    typedef enum logic [1:0] {StUnlocked, StLocking, StLocked} state_e;

    state_e          state_q, state_d;
    logic [3:0]      run_q, run_d;
    logic [CW-1:0]   count_q, count_d;
    logic [7:0]      err_q, err_d;
    logic            cv_q, cv_d, ce_q, ce_d, se_q, se_d, locked_q;

    logic [WIDTH-1:0] sample;
    logic [WIDTH-2:0] edges;
    logic [CW:0]      pop, idx_full, succ_full;
    logic [CW-1:0]    idx, succ_idx;
    logic             legal, is_hold, is_succ, err_inc;

    // Gate the input so X on an unstrobed word cannot reach the decode logic.
    always_comb begin
        sample = Valid_in ? Johnson_in : '0;
        edges  = sample[WIDTH-1:1] ^ sample[WIDTH-2:0];
        legal  = $onehot0(edges);
        pop    = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            pop = pop + {{CW{1'b0}}, sample[i]};
        end
        idx_full  = sample[WIDTH-1] ? (ModVal - pop) : pop;
        idx       = idx_full[CW-1:0];
        succ_full = {1'b0, count_q} + 1'b1;
        succ_idx  = (succ_full == ModVal) ? '0 : succ_full[CW-1:0];
        is_hold   = (idx == count_q);
        is_succ   = (idx == succ_idx);
    end

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        count_d = count_q;
        cv_d    = 1'b0;
        ce_d    = 1'b0;
        se_d    = 1'b0;
        err_inc = 1'b0;
        if (Valid_in) begin
            if (!legal) begin
                ce_d    = 1'b1;
                err_inc = 1'b1;
                state_d = StUnlocked;
            end else begin
                cv_d    = 1'b1;
                count_d = idx;
                unique case (state_q)
                    StUnlocked: begin
                        run_d   = '0;
                        state_d = StLocking;
                    end
                    StLocking: begin
                        if (is_succ) begin
                            run_d = run_q + 4'd1;
                            if (run_q + 4'd1 == LockRun) state_d = StLocked;
                        end else if (!is_hold) begin
                            run_d = '0;
                        end
                    end
                    StLocked: begin
                        if (!is_succ && !is_hold) begin
                            se_d    = 1'b1;
                            err_inc = 1'b1;
                            state_d = StUnlocked;
                        end
                    end
                    default: state_d = StUnlocked;
                endcase
            end
        end
        err_d = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= StUnlocked;
            run_q    <= '0;
            count_q  <= '0;
            err_q    <= '0;
            cv_q     <= 1'b0;
            ce_q     <= 1'b0;
            se_q     <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            run_q    <= run_d;
            count_q  <= count_d;
            err_q    <= err_d;
            cv_q     <= cv_d;
            ce_q     <= ce_d;
            se_q     <= se_d;
            locked_q <= (state_d == StLocked);
        end
    end

    assign Count_out   = count_q;
    assign Count_valid = cv_q;
    assign Code_error  = ce_q;
    assign Seq_error   = se_q;
    assign Locked      = locked_q;
    assign Error_count = err_q;

endmodule

// File: tb/tb_johnson_decoder.sv
// Directed scoreboard bench for johnson_decoder (WIDTH=4, LOCK_COUNT=2).
module tb_johnson_decoder;

    logic       Clock, Reset, Valid_in;
    logic [3:0] Johnson_in;
    logic [2:0] Count_out;
    logic       Count_valid, Code_error, Seq_error, Locked;
    logic [7:0] Error_count;

    int compared   = 0;
    int mismatched = 0;

    // {cnt, cv, ce, se, lk, err}
    logic [14:0] sb_q[$];
    string       tag_q[$];

    johnson_decoder #(.WIDTH(4), .LOCK_COUNT(2)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Valid_in   (Valid_in),
        .Johnson_in (Johnson_in),
        .Count_out  (Count_out),
        .Count_valid(Count_valid),
        .Code_error (Code_error),
        .Seq_error  (Seq_error),
        .Locked     (Locked),
        .Error_count(Error_count)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic step(input logic v, input logic r, input logic [3:0] j, input string tag,
                        input logic [2:0] c, input logic cv, input logic ce, input logic se,
                        input logic lk, input logic [7:0] e);
        logic [14:0] obs, exp_v;
        string       t;
        @(negedge Clock);
        Valid_in   = v;
        Reset      = r;
        Johnson_in = j;
        sb_q.push_back({c, cv, ce, se, lk, e});
        tag_q.push_back(tag);
        @(posedge Clock);
        #1;
        exp_v = sb_q.pop_front();
        t     = tag_q.pop_front();
        obs   = {Count_out, Count_valid, Code_error, Seq_error, Locked, Error_count};
        compared++;
        assert (obs === exp_v) else begin
            mismatched++;
            $error("FAIL %s: observed cnt=%0d cv=%b ce=%b se=%b lk=%b err=%0d expected cnt=%0d cv=%b ce=%b se=%b lk=%b err=%0d",
                   t, obs[14:12], obs[11], obs[10], obs[9], obs[8], obs[7:0],
                   exp_v[14:12], exp_v[11], exp_v[10], exp_v[9], exp_v[8], exp_v[7:0]);
        end
    endtask

    initial begin
        Reset      = 1'b1;
        Valid_in   = 1'b0;
        Johnson_in = 4'b0000;
        repeat (2) @(posedge Clock);

        // Reset wins over a valid sample on the same edge
        step(1, 1, 4'b0111, "reset",     3'd0, 0, 0, 0, 0, 8'd0);
        // Acquire lock from 0 and wrap around
        step(1, 0, 4'b0000, "s0",        3'd0, 1, 0, 0, 0, 8'd0);
        step(1, 0, 4'b0001, "s1",        3'd1, 1, 0, 0, 0, 8'd0);
        step(1, 0, 4'b0011, "s2_lock",   3'd2, 1, 0, 0, 1, 8'd0);
        step(1, 0, 4'b0111, "s3",        3'd3, 1, 0, 0, 1, 8'd0);
        step(1, 0, 4'b1111, "s4",        3'd4, 1, 0, 0, 1, 8'd0);
        step(1, 0, 4'b1110, "s5",        3'd5, 1, 0, 0, 1, 8'd0);
        step(1, 0, 4'b1100, "s6",        3'd6, 1, 0, 0, 1, 8'd0);
        step(1, 0, 4'b1000, "s7",        3'd7, 1, 0, 0, 1, 8'd0);
        step(1, 0, 4'b0000, "wrap",      3'd0, 1, 0, 0, 1, 8'd0);
        step(1, 0, 4'b0001, "w1",        3'd1, 1, 0, 0, 1, 8'd0);
        step(1, 0, 4'b0011, "w2",        3'd2, 1, 0, 0, 1, 8'd0);
        step(1, 0, 4'b0111, "w3",        3'd3, 1, 0, 0, 1, 8'd0);
        // Illegal code while locked; then an X word with no strobe
        step(1, 0, 4'b0101, "code_err",  3'd3, 0, 1, 0, 0, 8'd1);
        step(0, 0, 4'bxxxx, "x_idle",    3'd3, 0, 0, 0, 0, 8'd1);
        // Relock at 2, then skip to 5
        step(1, 0, 4'b0000, "r0",        3'd0, 1, 0, 0, 0, 8'd1);
        step(1, 0, 4'b0001, "r1",        3'd1, 1, 0, 0, 0, 8'd1);
        step(1, 0, 4'b0011, "r2_lock",   3'd2, 1, 0, 0, 1, 8'd1);
        step(1, 0, 4'b1110, "seq_err",   3'd5, 1, 0, 1, 0, 8'd2);
        // Same skip while locking restarts the run silently
        step(1, 0, 4'b0000, "l0",        3'd0, 1, 0, 0, 0, 8'd2);
        step(1, 0, 4'b0001, "l1",        3'd1, 1, 0, 0, 0, 8'd2);
        step(1, 0, 4'b1110, "lk_skip",   3'd5, 1, 0, 0, 0, 8'd2);
        step(1, 0, 4'b1100, "lk_run1",   3'd6, 1, 0, 0, 0, 8'd2);
        step(1, 0, 4'b1000, "lk_run2",   3'd7, 1, 0, 0, 1, 8'd2);
        // Holds with gaps while locked
        step(1, 0, 4'b0000, "h0",        3'd0, 1, 0, 0, 1, 8'd2);
        step(1, 0, 4'b0001, "h1",        3'd1, 1, 0, 0, 1, 8'd2);
        step(1, 0, 4'b0011, "h2",        3'd2, 1, 0, 0, 1, 8'd2);
        step(0, 0, 4'b0000, "gap_a",     3'd2, 0, 0, 0, 1, 8'd2);
        step(1, 0, 4'b0011, "hold_a",    3'd2, 1, 0, 0, 1, 8'd2);
        step(0, 0, 4'b1010, "gap_b",     3'd2, 0, 0, 0, 1, 8'd2);
        step(1, 0, 4'b0011, "hold_b",    3'd2, 1, 0, 0, 1, 8'd2);
        step(1, 0, 4'b0111, "after_hold",3'd3, 1, 0, 0, 1, 8'd2);
        // Saturate the error counter
        for (int i = 1; i <= 300; i++) begin
            step(1, 0, 4'b0101, "sat", 3'd3, 0, 1, 0, 0, (2 + i > 255) ? 8'd255 : 8'(2 + i));
        end
        // Reset while locking
        step(1, 0, 4'b0000, "pre_rst",   3'd0, 1, 0, 0, 0, 8'd255);
        step(1, 1, 4'b0001, "mid_rst",   3'd0, 0, 0, 0, 0, 8'd0);
        step(1, 0, 4'b0011, "post_r0",   3'd2, 1, 0, 0, 0, 8'd0);
        step(1, 0, 4'b0111, "post_r1",   3'd3, 1, 0, 0, 0, 8'd0);
        step(1, 0, 4'b1111, "post_r2",   3'd4, 1, 0, 0, 1, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
